// File: rtl/add_sub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM encodings and
// the default operand width.
package add_sub_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : add_sub_pkg

// File: rtl/full_adder_1b.sv
// Combinational one-bit full adder; the per-bit slice of the serial datapath.
module full_adder_1b (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic s,
   output logic cout
);

   assign s    = a ^ b ^ cin;
   assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_1b

// File: rtl/mux_2_to_1.sv
// Single-bit 2:1 multiplexer: y = sel ? in1 : in0.
module mux_2_to_1 (
   input  logic in0,
   input  logic in1,
   input  logic sel,
   output logic y
);

   assign y = sel ? in1 : in0;

endmodule : mux_2_to_1

// File: rtl/serial_add_sub.sv
// Bit-serial WIDTH-bit adder/subtractor: latches operands on start, then
// resolves one bit per clock LSB first and pulses done with the final flags.
module serial_add_sub
   import add_sub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             busy,
   output logic             done
);

   localparam int CNT_W = $clog2(WIDTH);

   state_t             state;
   state_t             next_state;
   logic [WIDTH-1:0]   a_sr;
   logic [WIDTH-1:0]   b_sr;
   logic [CNT_W-1:0]   bit_cnt;
   logic               sub_r;
   logic               carry;
   logic               carry_in_msb;
   logic               res_valid;
   logic               bb;
   logic               fa_s;
   logic               fa_cout;
   logic               last_bit;
   logic               accept;

   assign accept   = (state == IDLE) && start;
   assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));

   mux_2_to_1 u_b_inv (
      .in0 (b_sr[0]),
      .in1 (~b_sr[0]),
      .sel (sub_r),
      .y   (bb)
   );

   full_adder_1b u_slice (
      .a    (a_sr[0]),
      .b    (bb),
      .cin  (carry),
      .s    (fa_s),
      .cout (fa_cout)
   );

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // NOTE: next_state gets a default before the case so no path leaves it
   // unassigned, which would infer a latch.
   always_comb begin
      next_state = state;
      unique case (state)
         IDLE:    if (start) next_state = RUN;
         RUN:     if (last_bit) next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      busy = (state == RUN);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sr         <= '0;
         b_sr         <= '0;
         bit_cnt      <= '0;
         sub_r        <= 1'b0;
         carry        <= 1'b0;
         carry_in_msb <= 1'b0;
         res_valid    <= 1'b0;
         result       <= '0;
      end else if (accept) begin
         a_sr         <= a;
         b_sr         <= b;
         bit_cnt      <= '0;
         sub_r        <= sub;
         carry        <= sub;   // +1 of the two's complement negate
         carry_in_msb <= 1'b0;
         res_valid    <= 1'b0;
         result       <= '0;
      end else if (state == RUN) begin
         a_sr    <= a_sr >> 1;
         b_sr    <= b_sr >> 1;
         bit_cnt <= bit_cnt + CNT_W'(1);
         carry   <= fa_cout;
         result  <= {fa_s, result[WIDTH-1:1]};
         if (last_bit) begin
            carry_in_msb <= carry;
            res_valid    <= 1'b1;
         end
      end
   end

   // carry stops moving once RUN ends, so the flags hold until the next accept
   assign cout     = res_valid & carry;
   assign overflow = res_valid & (carry_in_msb ^ carry);

endmodule : serial_add_sub

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub (WIDTH = 8): directed vector table
// plus hand-written protocol, held-start and mid-run reset sequences.
module tb_serial_add_sub;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] result;
   logic         cout;
   logic         overflow;
   logic         busy;
   logic         done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic [W-1:0] res;
      logic         co;
      logic         ov;
   } vec_t;

   vec_t vecs[9];

   serial_add_sub #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .result   (result),
      .cout     (cout),
      .overflow (overflow),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   // Drive one operation and check busy window, done timing and results.
   task automatic run_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vs, input logic [W-1:0] eres, input logic eco,
                         input logic eov);
      int bad_busy;
      @(negedge clk);
      a = va; b = vb; sub = vs; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      bad_busy = 0;
      for (int c = 0; c < W; c++) begin
         @(negedge clk);
         if (busy !== 1'b1 || done !== 1'b0) bad_busy++;
      end
      check({tag, " busy_window_bad_cycles"}, bad_busy, 0);
      @(negedge clk);
      check({tag, " done"}, {busy, done}, 2'b01);
      check({tag, " result"}, result, eres);
      check({tag, " cout"}, cout, eco);
      check({tag, " overflow"}, overflow, eov);
      @(negedge clk);
      check({tag, " idle_after"}, {busy, done}, 2'b00);
   endtask

   initial begin
      int done_cnt;
      int done_cyc;
      logic [W-1:0] res_at_done;

      vecs[0] = '{8'd100, 8'd27,  1'b0, 8'd127, 1'b0, 1'b0};
      vecs[1] = '{8'd100, 8'd28,  1'b0, 8'h80,  1'b0, 1'b1};
      vecs[2] = '{8'd5,   8'd7,   1'b1, 8'hFE,  1'b0, 1'b0};
      vecs[3] = '{8'd7,   8'd5,   1'b1, 8'd2,   1'b1, 1'b0};
      vecs[4] = '{8'h80,  8'h01,  1'b1, 8'h7F,  1'b1, 1'b1};
      vecs[5] = '{8'hFF,  8'h01,  1'b0, 8'h00,  1'b1, 1'b0};
      vecs[6] = '{8'h80,  8'h80,  1'b0, 8'h00,  1'b1, 1'b1};
      vecs[7] = '{8'h00,  8'h00,  1'b1, 8'h00,  1'b1, 1'b0};
      vecs[8] = '{8'h7F,  8'hFF,  1'b1, 8'h80,  1'b0, 1'b1};

      rst = 1'b1; start = 1'b0; sub = 1'b0; a = '0; b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset outputs", {result, cout, overflow, busy, done}, '0);
      rst = 1'b0;

      for (int i = 0; i < 9; i++)
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sub,
                vecs[i].res, vecs[i].co, vecs[i].ov);

      // Protocol: second start while busy ignored, operand changes ignored.
      @(negedge clk);
      a = 8'h10; b = 8'h01; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      done_cnt = 0; done_cyc = -1; res_at_done = '0;
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (done === 1'b1) begin
            done_cnt++;
            done_cyc = c;
            res_at_done = result;
         end
         if (c == 2) begin a = 8'hFF; b = 8'h55; sub = 1'b1; start = 1'b1; end
         if (c == 3) start = 1'b0;
         if (c == 5) begin a = 8'h33; b = 8'h44; end
      end
      check("proto done_count", done_cnt, 1);
      check("proto done_cycle", done_cyc, 8);
      check("proto result", res_at_done, 8'h11);
      check("proto result_held", result, 8'h11);

      // Start held high is re-accepted at the first IDLE cycle.
      @(negedge clk);
      a = 8'd1; b = 8'd1; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      for (int c = 0; c <= 10; c++) begin
         @(negedge clk);
         if (c == 8) check("held done", done, 1'b1);
         if (c == 9) check("held idle_gap", busy, 1'b0);
         if (c == 10) check("held reaccept", busy, 1'b1);
      end
      start = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 20 && done_cnt == 0; c++) begin
         @(negedge clk);
         if (done === 1'b1) done_cnt = 1;
      end
      check("held second_done_seen", done_cnt, 1);
      check("held second_result", result, 8'd2);

      // Reset mid-run aborts; rst also beats a simultaneous start.
      @(negedge clk);
      a = 8'h20; b = 8'h03; sub = 1'b0; start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 0; c < 4; c++) @(negedge clk);
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      check("abort outputs", {result, cout, overflow, busy, done}, '0);
      rst = 1'b0; start = 1'b0;
      done_cnt = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_cnt++;
      end
      check("abort no_activity", done_cnt, 0);
      run_op("after_abort", 8'd3, 8'd4, 1'b0, 8'd7, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_add_sub

// File: doc/serial_add_sub.md
# serial_add_sub

Bit-serial WIDTH-bit adder/subtractor for the adder_subs design. It latches two operands and an add/sub select on a start pulse, then processes one bit per clock, LSB first, through a single full-adder slice. The B operand is conditionally inverted per bit by the existing mux_2_to_1, with sel = sub. It reports result, carry-out and signed overflow with a one-cycle done pulse, and is the control/datapath stage that drives that mux.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; accepted only in IDLE.
- sub  in  1  0 = A+B, 1 = A−B; latched at accept.
- a  in  WIDTH  operand A; latched at accept.
- b  in  WIDTH  operand B; latched at accept.
- result  out  WIDTH  sum/difference; held until next accept.
- cout  out  1  final carry-out; for subtract, 1 means no borrow (A ≥ B unsigned).
- overflow  out  1  signed overflow: carry into MSB XOR carry out of MSB.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse in DONE.

## Operation
- States: IDLE, RUN, DONE.
- IDLE → RUN on start:
  - Load shift registers A_sr ← a and B_sr ← b.
  - Latch sub_r ← sub.
  - Set carry ← sub (the +1 of two's complement).
  - Set bit counter ← 0.
  - Clear result, cout and overflow to 0.
- RUN, each edge:
  - bb = sub_r ? ~B_sr[0] : B_sr[0] (mux_2_to_1).
  - s = A_sr[0] ^ bb ^ carry.
  - carry ← majority(A_sr[0], bb, carry).
  - result shifts right with s inserted at the MSB.
  - A_sr and B_sr shift right.
  - Counter increments.
  - On the bit WIDTH−1 edge: capture carry_in_msb ← the carry before update, then go to DONE.
- DONE:
  - cout = carry.
  - overflow = carry_in_msb ^ carry.
  - done = 1.
  - Next edge goes to IDLE unconditionally.
- start in RUN or DONE is ignored; it is not queued.
- Input changes after accept have no effect.
- Arithmetic is modulo 2^WIDTH. Counter width is $clog2(WIDTH).

## Timing
- Reset values:
  - State IDLE.
  - result = 0, cout = 0, overflow = 0, busy = 0, done = 0.
  - Internal registers 0.
- Reset has priority over everything. Reset asserted in RUN or DONE aborts the operation: the next cycle is IDLE with all outputs 0 and no done pulse.
- Latency: start sampled at edge 0.
  - busy is high for the WIDTH cycles after edges 0..WIDTH−1.
  - done is high for exactly the one cycle after edge WIDTH.
  - IDLE resumes after edge WIDTH+1.
- Throughput: one operation per WIDTH+2 cycles. A start held high continuously is re-accepted at the first IDLE cycle.
- result, cout and overflow are valid from the done cycle and hold until the next accepted start clears them.
- start and rst asserted together: rst wins, start is not accepted.

## Structure
- Package add_sub_pkg holds:
  - State encodings: IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2.
  - Default WIDTH constant.
- Sub-module full_adder_1b (a, b, cin → s, cout) is the per-bit slice. It is combinational.
- The existing mux_2_to_1 is instantiated for the B-inversion select.
- The FSM, shift registers, counter and carry registers are in serial_add_sub.

## Test plan
All scenarios use WIDTH = 8.
- Add, no overflow: a=100, b=27, sub=0 → result=127, cout=0, overflow=0. done exactly 8 cycles after the start edge; busy high for 8 cycles.
- Add, signed overflow: a=100, b=28, sub=0 → result=0x80, cout=0, overflow=1.
- Subtract with borrow: a=5, b=7, sub=1 → result=0xFE, cout=0, overflow=0.
- Subtract edge cases:
  - a=7, b=5, sub=1 → result=2, cout=1, overflow=0.
  - a=0x80, b=1, sub=1 → result=0x7F, cout=1, overflow=1.
- Protocol:
  - Start with a=0x10, b=0x01.
  - Pulse start again with a=0xFF at cycle 3 → ignored; result=0x11 with a single done pulse.
  - Change a and b while busy → no effect on result.
- Reset mid-run: start, assert rst at cycle 4 → next cycle IDLE, busy=0, done never pulses, outputs 0. A following start of 3+4 completes normally with result=7.
